// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver with a tear-free double buffer; outputs registered, one cycle after idx moves.
// No backpressure: load is always accepted. Optional leading-zero blanking via `define SEG_SCAN_LZB_EN.
module seg_scan_driver #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  load,
    output logic [7:0]            SEGMENTS,
    output logic [DIGITS-1:0]     AN,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    // XOR masks turn the internal active-low form into the board polarity.
    localparam logic [7:0]        SEG_POL  = (ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;
    localparam logic [DIGITS-1:0] AN_POL   = (ACTIVE_LOW != 0) ? '0 : '1;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

`ifdef SEG_SCAN_LZB_EN
    // A digit is suppressed while it and everything above it are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] v);
        logic zero_run;
        zero_run = 1'b1;
        lzb_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (v[4*i +: 4] == 4'h0);
            lzb_mask[i] = zero_run;
        end
    endfunction

    logic [DIGITS-1:0]   disp_sup;
`endif

    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] sh_val, disp_val;
    logic [DIGITS-1:0]   sh_dp, sh_blank, disp_dp, disp_blank;
    logic                pending;
    logic                tick, wrap;

    logic [3:0]          cur_nib;
    logic                cur_dp, cur_blank, cur_sup;
    logic [7:0]          seg_al;
    logic [DIGITS-1:0]   an_al;

    assign tick = (pre == PRE_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_sup   = 1'b0;
        an_al     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = disp_val[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = disp_blank[i];
`ifdef SEG_SCAN_LZB_EN
                cur_sup   = disp_sup[i];
`endif
                an_al[i]  = 1'b0;
            end
        end
        seg_al = 8'hFF;
        if (!cur_blank) begin
            seg_al = {~cur_dp, cur_sup ? 7'h7F : decode(cur_nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            idx        <= '0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            pending    <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
`ifdef SEG_SCAN_LZB_EN
            disp_sup   <= '0;
`endif
            SEGMENTS   <= ~SEG_POL;
            AN         <= ~AN_POL;
            frame_done <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_mask;
                sh_blank <= blank_mask;
            end

            // A load landing on the wrap bypasses the shadow so it is not held a whole frame.
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    disp_val   <= value;
                    disp_dp    <= dp_mask;
                    disp_blank <= blank_mask;
`ifdef SEG_SCAN_LZB_EN
                    disp_sup   <= lzb_mask(value);
`endif
                end else if (pending) begin
                    disp_val   <= sh_val;
                    disp_dp    <= sh_dp;
                    disp_blank <= sh_blank;
`ifdef SEG_SCAN_LZB_EN
                    disp_sup   <= lzb_mask(sh_val);
`endif
                end
            end else if (load) begin
                pending <= 1'b1;
            end

            SEGMENTS   <= seg_al ^ SEG_POL;
            AN         <= an_al ^ AN_POL;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level model queues expected slots, a monitor pops them on every digit change.
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int AL = 1;
    localparam int FR = D * SD;
    localparam logic [7:0]   SEG_OFF = (AL != 0) ? 8'hFF : 8'h00;
    localparam logic [D-1:0] AN_OFF  = (AL != 0) ? '1 : '0;
    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef struct packed {
        logic [4*D-1:0] v;
        logic [D-1:0]   dp;
        logic [D-1:0]   bl;
    } frame_t;

    typedef struct packed {
        logic [D-1:0] an;
        logic [7:0]   seg;
    } slot_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*D-1:0] value = '0;
    logic [D-1:0]   dp_mask = '0;
    logic [D-1:0]   blank_mask = '0;
    logic           load = 1'b0;
    logic [7:0]     SEGMENTS;
    logic [D-1:0]   AN;
    logic           frame_done;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     k = 0;
    int     slots = 0;
    frame_t latest = '0;
    slot_t  exp_q[$];
    logic [D-1:0] prev_an = '1;
    logic [7:0]   last_seg = '1;

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(AL)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .load(load), .SEGMENTS(SEGMENTS),
        .AN(AN), .frame_done(frame_done));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    function automatic slot_t expect_slot(input frame_t f, input int s);
        slot_t r;
        logic [3:0] nib;
        nib   = f.v[4*s +: 4];
        r.an  = ~(D'(1) << s);
        if (f.bl[s]) begin
            r.seg = 8'hFF;
        end else begin
            r.seg[7]   = ~f.dp[s];
            r.seg[6:0] = SEG_TBL[nib];
`ifdef SEG_SCAN_LZB_EN
            if (s != 0 && (f.v >> (4*s)) == 0) r.seg[6:0] = 7'h7F;
`endif
        end
        if (AL == 0) begin
            r.seg = ~r.seg;
            r.an  = ~r.an;
        end
        return r;
    endfunction

    task automatic push_frame(input frame_t f);
        for (int s = 0; s < D; s++) exp_q.push_back(expect_slot(f, s));
    endtask

    // Reference: each frame shows the most recent load captured at or before its wrap edge.
    always @(posedge clk) begin
        if (rst_n) begin
            k++;
            if (load) latest = {value, dp_mask, blank_mask};
            if (k % FR == 0) push_frame(latest);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_seg", 32'(SEGMENTS), 32'(SEG_OFF));
            check("reset_an", 32'(AN), 32'(AN_OFF));
            check("reset_fd", 32'(frame_done), 32'd0);
            prev_an = AN_OFF;
        end else begin
            if (AN !== prev_an) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_slot: got an=%b expected no slot change", AN);
                end else begin
                    slot_t e;
                    e = exp_q.pop_front();
                    check("slot_an", 32'(AN), 32'(e.an));
                    check("slot_seg", 32'(SEGMENTS), 32'(e.seg));
                end
                slots++;
                prev_an  = AN;
                last_seg = SEGMENTS;
            end else if (prev_an === AN_OFF) begin
                check("pre_scan_seg", 32'(SEGMENTS), 32'(SEG_OFF));
            end else begin
                check("seg_hold", 32'(SEGMENTS), 32'(last_seg));
            end
            if (frame_done || (k > 0 && k % FR == 0))
                check("frame_done", 32'(frame_done), 32'(k > 0 && k % FR == 0));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        load   = 1'b0;
        k      = 0;
        latest = '0;
        exp_q.delete();
        push_frame('0);
        tick_n(3);
        rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [4*D-1:0] v, input logic [D-1:0] dp, input logic [D-1:0] bl);
        value      = v;
        dp_mask    = dp;
        blank_mask = bl;
        load       = 1'b1;
        tick_n(1);
        load       = 1'b0;
    endtask

    task automatic wait_before_wrap();
        for (int i = 0; i <= FR && ((k + 1) % FR != 0); i++) tick_n(1);
    endtask

    initial begin
        #1;
        do_reset();
        tick_n(2);
        do_load(16'h12AF, 4'b0000, 4'b0000);
        tick_n(2 * FR);
        value = 16'h3333;
        tick_n(FR + 3);
        do_load(16'h3333, 4'b0000, 4'b0000);
        tick_n(2 * FR);
        wait_before_wrap();
        do_load(16'h0009, 4'b0000, 4'b0000);
        tick_n(2 * FR);
        do_load(16'h12AF, 4'b0010, 4'b1000);
        tick_n(2 * FR);
        do_load(16'h0050, 4'b0000, 4'b0000);
        tick_n(2 * FR);
        do_load(16'h0000, 4'b0001, 4'b0000);
        tick_n(2 * FR);

        for (int i = 0; i < 3000; i++) begin
            value      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_mask    = D'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
            load       = ($urandom_range(0, 15) == 0);
            if (i == 1500) begin
                do_load(16'hBEEF, 4'b0101, 4'b0000);
                tick_n($urandom_range(0, FR - 1));
                do_reset();
            end else begin
                tick_n(1);
            end
        end
        load = 1'b0;
        tick_n(2 * FR);
        wait_before_wrap();
        do_load(16'h4D7C, 4'b1000, 4'b0000);
        tick_n(2 * FR);

        check("progress", 32'(slots > 500), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

endmodule
